// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types, default widths and helpers for the regfile_mp
// register file and its read-port sub-module.
//   rf_state_e   : clear-sweep / run state encoding
//   RF_ADDR_W    : default address width
//   RF_DATA_W    : default data width
//   even_parity(): even-parity bit for an entry (callers zero-extend)
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

    localparam int RF_ADDR_W    = 5;
    localparam int RF_DATA_W    = 32;
    // Widest data word the parity helper accepts; zero-extension does not
    // change parity, so any narrower entry can be passed in.
    localparam int RF_PAR_MAX_W = 256;

    function automatic logic even_parity(input logic [RF_PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: one registered read port of regfile_mp.
// Resolves the read value (zero register, out-of-range, write bypass, stored
// entry), registers it when re is high in RUN and holds it otherwise.
// Optional macro REGFILE_PARITY_EN adds stored_par input and par_err output.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   run             register file is past its clear sweep
//   re, addr        read enable and address of this port
//   wr_eff          the write port performs a real write this cycle
//   write_addr, din write port address/data for the bypass
//   stored          entry currently stored at addr
//   stored_par      stored parity bit of that entry (parity build only)
//   dout            registered read data
//   par_err         registered parity error flag (parity build only)
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_W,
    parameter int DATA_WIDTH = RF_DATA_W,
    parameter int RAM_SIZE   = 32,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  wr_eff,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [DATA_WIDTH-1:0] stored,
`ifdef REGFILE_PARITY_EN
    input  logic                  stored_par,
    output logic                  par_err,
`endif
    output logic [DATA_WIDTH-1:0] dout
);

    localparam logic [ADDR_WIDTH:0] RAM_SIZE_X = (ADDR_WIDTH+1)'(RAM_SIZE);

    logic                  force_zero;
    logic                  bypass;
    logic [DATA_WIDTH-1:0] rd_val;

    always_comb begin
        force_zero = ((ZERO_REG != 0) && (addr == '0)) || ({1'b0, addr} >= RAM_SIZE_X);
        // wr_eff is already false for suppressed writes, so they never bypass.
        bypass     = wr_eff && (write_addr == addr);
        rd_val     = stored;
        if (force_zero) begin
            rd_val = '0;
        end else if (bypass) begin
            rd_val = din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else if (run && re) begin
            dout <= rd_val;
        end
    end

`ifdef REGFILE_PARITY_EN
    logic par_bad;

    always_comb begin
        par_bad = 1'b0;
        if (!force_zero && !bypass) begin
            par_bad = (even_parity(RF_PAR_MAX_W'(stored)) != stored_par);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            par_err <= 1'b0;
        end else if (run && re) begin
            par_err <= par_bad;
        end
    end
`endif

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: one-write, NUM_READ-read register file for the RV32IC datapath.
// After reset a sweep clears one entry per cycle; ready rises in the first
// RUN cycle. Writes and reads are honoured only in RUN. Each read port is a
// regfile_rdport with write-first bypass.
// Optional macro REGFILE_PARITY_EN: per-entry even parity and par_err output.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   we, write_addr, din   write port
//   re          per-port read enable
//   read_addr   packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   dout        packed registered read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ready       clear sweep complete
//   par_err     per-port parity error (parity build only)
//
// state | meaning
// CLEAR | writing 0 to entry clr_idx each cycle; we/re ignored, ready=0
// RUN   | normal operation, ready=1
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_W,
    parameter int DATA_WIDTH = RF_DATA_W,
    parameter int RAM_SIZE   = 32,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             we,
    input  logic [ADDR_WIDTH-1:0]            write_addr,
    input  logic [DATA_WIDTH-1:0]            din,
    input  logic [NUM_READ-1:0]              re,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]   read_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0]   dout,
    output logic                             ready
`ifdef REGFILE_PARITY_EN
    ,
    output logic [NUM_READ-1:0]              par_err
`endif
);

    localparam logic [ADDR_WIDTH:0]   RAM_SIZE_X = (ADDR_WIDTH+1)'(RAM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(RAM_SIZE - 1);

    rf_state_e             state, state_nxt;
    logic [ADDR_WIDTH-1:0] clr_idx;
    logic                  clr_en;
    logic                  run;
    logic                  wr_eff;

    logic [DATA_WIDTH-1:0] mem [RAM_SIZE];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state <= state_nxt;
            if (clr_en) begin
                clr_idx <= (clr_idx == LAST_IDX) ? '0 : clr_idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_idx == LAST_IDX) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        clr_en = (state == CLEAR);
        run    = (state == RUN);
        ready  = run;
        // rst gates the write so a reset cycle in RUN cannot sneak one in.
        wr_eff = run && we && !rst
                 && ({1'b0, write_addr} < RAM_SIZE_X)
                 && !((ZERO_REG != 0) && (write_addr == '0));
    end

    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_idx] <= '0;
        end else if (wr_eff) begin
            mem[write_addr] <= din;
        end
    end

`ifdef REGFILE_PARITY_EN
    logic pmem [RAM_SIZE];

    always_ff @(posedge clk) begin
        if (clr_en) begin
            pmem[clr_idx] <= 1'b0;
        end else if (wr_eff) begin
            pmem[write_addr] <= even_parity(RF_PAR_MAX_W'(din));
        end
    end
`endif

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] stored;

        assign ra = read_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        // Out-of-range addresses are forced to 0 inside the port.
        assign stored = mem[ra];

        regfile_rdport #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .RAM_SIZE   (RAM_SIZE),
            .ZERO_REG   (ZERO_REG)
        ) u_rdport (
            .clk        (clk),
            .rst        (rst),
            .run        (run),
            .re         (re[i]),
            .addr       (ra),
            .wr_eff     (wr_eff),
            .write_addr (write_addr),
            .din        (din),
            .stored     (stored),
`ifdef REGFILE_PARITY_EN
            .stored_par (pmem[ra]),
            .par_err    (par_err[i]),
`endif
            .dout       (dout[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp. Main instance uses default
// parameters; a second instance (ZERO_REG=0, RAM_SIZE=24) shares the inputs
// to cover an ordinary x0 and out-of-range addresses.
// Parity checks are compiled only with REGFILE_PARITY_EN.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  write_addr;
    logic [31:0] din;
    logic [1:0]  re;
    logic [9:0]  read_addr;
    logic [63:0] dout;
    logic        ready;
    logic [63:0] nz_dout;
    logic        nz_ready;
`ifdef REGFILE_PARITY_EN
    logic [1:0]  par_err;
    logic [1:0]  nz_par_err;
`endif

    logic        nz_chk;
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    logic [31:0] exp_nz[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .write_addr (write_addr),
        .din        (din),
        .re         (re),
        .read_addr  (read_addr),
        .dout       (dout),
        .ready      (ready)
`ifdef REGFILE_PARITY_EN
        ,
        .par_err    (par_err)
`endif
    );

    regfile_mp #(.RAM_SIZE(24), .ZERO_REG(0)) dut_nz (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .write_addr (write_addr),
        .din        (din),
        .re         (re),
        .read_addr  (read_addr),
        .dout       (nz_dout),
        .ready      (nz_ready)
`ifdef REGFILE_PARITY_EN
        ,
        .par_err    (nz_par_err)
`endif
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: at each negedge first score the reads captured by the edge just
    // passed, then note which reads the coming edge will capture.
    initial begin
        logic [1:0]  pend;
        logic        pnz;
        logic [31:0] e;
        pend = '0;
        pnz  = 1'b0;
        forever begin
            @(negedge clk);
            if (pend[0]) begin
                if (exp_q0.size() == 0) check("rd_p0_underflow", 1, 0);
                else begin e = exp_q0.pop_front(); check("rd_p0", 64'(dout[31:0]), 64'(e)); end
            end
            if (pend[1]) begin
                if (exp_q1.size() == 0) check("rd_p1_underflow", 1, 0);
                else begin e = exp_q1.pop_front(); check("rd_p1", 64'(dout[63:32]), 64'(e)); end
            end
            if (pnz) begin
                if (exp_nz.size() == 0) check("rd_nz_underflow", 1, 0);
                else begin e = exp_nz.pop_front(); check("rd_nz_p0", 64'(nz_dout[31:0]), 64'(e)); end
            end
            pend = re & {2{ready}} & {2{~rst}};
            pnz  = nz_chk & re[0] & nz_ready & ~rst;
        end
    end

    task automatic cyc(input logic w, input logic [4:0] wa, input logic [31:0] d,
                       input logic [1:0] r, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] e0, input logic [31:0] e1,
                       input logic nzc, input logic [31:0] enz);
        @(posedge clk); #1;
        we = w; write_addr = wa; din = d;
        re = r; read_addr = {a1, a0};
        nz_chk = nzc;
        if (r[0]) exp_q0.push_back(e0);
        if (r[1]) exp_q1.push_back(e1);
        if (nzc) exp_nz.push_back(enz);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        we = 1'b0; re = 2'b00; nz_chk = 1'b0;
    endtask

    // Called just after rst is released; ready must rise after 32 edges.
    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (!ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check(nm, 64'(n), 64'd32);
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; write_addr = '0; din = '0;
        re = '0; read_addr = '0; nz_chk = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_dout", dout, 64'd0);
        check("rst_nz_dout", nz_dout, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_ready("sweep_len");
        check("nz_ready", 64'(nz_ready), 64'd1);

        // Every entry cleared.
        for (int a = 0; a < 32; a += 2)
            cyc(0, 0, 0, 2'b11, 5'(a), 5'(a + 1), 0, 0, 0, 0);
        idle();

        // Write then read on both ports.
        cyc(1, 5, 32'hDEADBEEF, 2'b00, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 2'b11, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);

        // Bypass on both ports, then stored value.
        cyc(1, 7, 32'hAAAA0000, 2'b00, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 2'b10, 0, 7, 0, 32'hAAAA0000, 0, 0);
        cyc(1, 7, 32'h12345678, 2'b11, 7, 7, 32'h12345678, 32'h12345678, 0, 0);
        cyc(0, 0, 0, 2'b11, 7, 5, 32'h12345678, 32'hDEADBEEF, 0, 0);

        // x0: zero register on main instance, ordinary register on dut_nz.
        cyc(1, 0, 32'hFFFFFFFF, 2'b11, 0, 0, 0, 0, 1, 32'hFFFFFFFF);
        cyc(0, 0, 0, 2'b11, 0, 0, 0, 0, 1, 32'hFFFFFFFF);

        // Top entry and out-of-range on dut_nz (suppressed write, no bypass).
        cyc(1, 31, 32'h31313131, 2'b00, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 2'b11, 31, 30, 32'h31313131, 0, 0, 0);
        cyc(1, 30, 32'h5A5A5A5A, 2'b11, 30, 30, 32'h5A5A5A5A, 32'h5A5A5A5A, 1, 0);
        cyc(0, 0, 0, 2'b01, 30, 0, 32'h5A5A5A5A, 0, 1, 0);
        cyc(0, 0, 0, 2'b01, 23, 0, 0, 0, 1, 0);
        idle();

        // Mid-sweep reset restarts the full sweep.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_ready", 64'(ready), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        wait_ready("resweep_len");
        cyc(0, 0, 0, 2'b11, 5, 31, 0, 0, 0, 0);

        // Hold on re=0 while address changes.
        cyc(1, 5, 32'h0BADF00D, 2'b00, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 2'b01, 5, 0, 32'h0BADF00D, 0, 0, 0);
        cyc(0, 0, 0, 2'b00, 3, 4, 0, 0, 0, 0);
        cyc(0, 0, 0, 2'b00, 0, 9, 0, 0, 0, 0);
        @(negedge clk);
        check("hold_p0", 64'(dout[31:0]), 64'h0BADF00D);

`ifdef REGFILE_PARITY_EN
        cyc(1, 9, 32'h00000011, 2'b00, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 2'b11, 9, 9, 32'h00000011, 32'h00000011, 0, 0);
        idle();
        @(negedge clk);
        check("par_clean", 64'(par_err), 64'd0);
        dut.mem[9][3] = ~dut.mem[9][3];
        cyc(0, 0, 0, 2'b11, 9, 9, 32'h00000019, 32'h00000019, 0, 0);
        idle();
        @(negedge clk);
        check("par_flip", 64'(par_err), 64'd3);
        cyc(1, 9, 32'h00000022, 2'b11, 9, 9, 32'h00000022, 32'h00000022, 0, 0);
        idle();
        @(negedge clk);
        check("par_bypass", 64'(par_err), 64'd0);
`endif

        idle();
        repeat (3) @(posedge clk);
        check("drain", 64'(exp_q0.size() + exp_q1.size() + exp_nz.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-read-port register file for the RV32IC datapath.
- One write port and NUM_READ independent synchronous read ports.
- Write-to-read bypass on every read port.
- Architectural zero register.
- Sequenced post-reset clear, with a ready flag to the decode stage.
- Sits between IF/ID decode (read ports) and writeback (write port).

Parameters:
ADDR_WIDTH, 5, address width of every port
DATA_WIDTH, 32, width of each entry
RAM_SIZE, 32, number of entries (must be <= 2**ADDR_WIDTH)
NUM_READ, 2, number of read ports (>= 1)
ZERO_REG, 1, 1: entry 0 reads 0 and ignores writes; 0: entry 0 is an ordinary register

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous active-high reset
we  input  1  write enable
write_addr  input  ADDR_WIDTH  write address
din  input  DATA_WIDTH  write data
re  input  NUM_READ  per-port read enable
read_addr  input  NUM_READ*ADDR_WIDTH  packed read addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
dout  output  NUM_READ*DATA_WIDTH  packed registered read data; port i at [i*DATA_WIDTH +: DATA_WIDTH]
ready  output  1  high once the clear sweep has completed

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; it is sampled only on posedge clk.
- Reset values: state=CLEAR, clr_idx=0, ready=0, all dout=0.
- FSM CLEAR:
  - Each cycle writes 0 to entry clr_idx, then clr_idx++.
  - After the cycle that writes entry RAM_SIZE-1, go to RUN.
  - Sweep takes exactly RAM_SIZE cycles; ready is 1 from the first RUN cycle.
  - During CLEAR: we is ignored, re is ignored, dout holds 0.
- FSM RUN: stays in RUN until rst.
- rst asserted mid-sweep or in RUN: restart CLEAR at index 0. Partially cleared contents are not preserved.
- Write, RUN only:
  - On posedge with we=1, entry write_addr <= din.
  - Suppressed when write_addr >= RAM_SIZE.
  - Suppressed when write_addr==0 and ZERO_REG=1.
- Read (per port i), RUN only:
  - re[i]=1: dout_i updated on the next posedge; latency 1 cycle.
  - re[i]=0: dout_i holds its previous value.
- Read value priority, highest first:
  1. ZERO_REG=1 and addr==0 -> 0.
  2. addr >= RAM_SIZE -> 0.
  3. Effective write to the same address in the same cycle -> din (write-first bypass).
  4. Otherwise the stored entry.
- Simultaneous events:
  - All ports reading the same address receive identical data.
  - A bypass applies to every matching port at once.
  - A suppressed write never bypasses.
- No combinational path from any input to dout.

Optional Feature:
Macro: REGFILE_PARITY_EN
- Defined:
  - Each entry stores an extra even-parity bit computed from din; the clear sweep writes parity 0.
  - Adds output par_err [NUM_READ], registered alongside dout, reset 0.
  - par_err[i]=1 when the stored data plus parity read on port i mismatch.
  - Bypassed and zero-register reads always give par_err[i]=0.
- Undefined: no parity storage and no par_err port.

Decomposition:
- Package regfile_pkg:
  - typedef rf_state_e {CLEAR, RUN}.
  - Default-width constants RF_ADDR_W=5, RF_DATA_W=32.
  - Function for even parity.
- Sub-module regfile_rdport:
  - One registered read port: address check, zero/bypass mux, hold on !re, parity check.
  - Instantiated NUM_READ times via a generate loop.
- Storage array, write logic and clear FSM stay in regfile_mp.

Test Plan:
1. Reset sweep: pulse rst 1 cycle, then idle -> ready=0 for exactly 32 cycles, then 1; reading every address returns 0x00000000.
2. Write/read: write 0xDEADBEEF to x5; next cycle re=2'b11 with both ports at addr 5 -> one cycle later both dout ports = 0xDEADBEEF.
3. Bypass: same cycle we=1, write_addr=7, din=0x12345678, port1 reads 7 (stored value 0xAAAA0000) -> dout port1 = 0x12345678 and the entry is updated.
4. Zero register: write 0xFFFFFFFF to x0 with a same-cycle read of 0 -> dout=0 now and on a later read. With ZERO_REG=0 the same stimulus -> dout = 0xFFFFFFFF.
5. Mid-sweep reset and hold: rst at sweep cycle 10 -> ready stays 0 for a further 32 cycles. After ready, re=0 on port0 while read_addr changes -> dout port0 unchanged.
6. Parity (REGFILE_PARITY_EN): force-flip bit 3 of the stored entry x9 by hierarchical write, then read x9 -> par_err[i]=1; a bypassed read of x9 -> par_err[i]=0.
